seg_dynamic_decoder: RTL and testbench
======================================

SEG_DYNAMIC_DECODER -- requirements
Module: seg_dynamic_decoder

Interface
REQ-001 SHALL have parameter CNT_STABLE, 16 bits, default 16'd1000: consecutive cycles a sel/seg pair must hold before the digit is latched.
REQ-002 SHALL have port sys_clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port seg, input, 8 bits: active-low segment bus; bit 7 is the decimal point, bits 6:0 are g..a.
REQ-005 SHALL have port sel, input, 6 bits: one-hot active-high digit select; sel[0] is the least significant digit.
REQ-006 SHALL have port data, output, 20 bits: reconstructed binary value.
REQ-007 SHALL have port point, output, 6 bits: point[i] is 1 when digit i shows a lit dp.
REQ-008 SHALL have port sign, output, 1 bit: 1 when any digit shows the minus glyph.
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when data, point and sign update.
REQ-010 SHALL have port glyph_err, output, 1 bit: sticky flag, set by an unrecognised glyph in the last frame.

Function
REQ-011 SHALL decode seg[6:0] as follows.
- Digits: 0=7'h40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Minus = 3F; blank = 7F.
- Minus and blank contribute value 0.
REQ-012 SHALL treat sel as valid only when exactly one bit is set; an invalid sel clears the stability counter and latches nothing.
REQ-013 SHALL restart the stability counter whenever sel or seg differs from its value in the previous cycle.
REQ-014 SHALL latch the glyph, dp and value of digit i when the counter reaches CNT_STABLE-1 with sel[i]=1, and set capture-mask bit i.
REQ-015 SHALL latch each digit at most once per stable dwell; the counter saturates until the next change.
REQ-016 SHALL run an FSM with three states.
- IDLE: enter CONVERT when the capture mask is 6'b111111.
- CONVERT: runs for exactly 6 cycles.
- DONE: lasts 1 cycle, then IDLE.
REQ-017 SHALL, on leaving IDLE, snapshot all six digit registers and clear the capture mask in the same cycle; capture continues during CONVERT and DONE.
REQ-018 SHALL, in CONVERT, compute acc = acc*10 + digit, taking digits from 5 down to 0; the multiply is done as (acc<<3)+(acc<<1), 20-bit.
- The maximum result is 999999, so no overflow is possible.
REQ-019 SHALL, in DONE, load data, point, sign and glyph_err, and assert frame_valid for that cycle only.
REQ-020 SHALL give a latency of 8 cycles from the cycle the sixth mask bit sets to frame_valid high.
REQ-021 SHALL hold data, point, sign and glyph_err stable between frame_valid pulses.
REQ-022 SHALL, when the mask completes during CONVERT or DONE, start the next conversion on the first IDLE cycle.

Reset
REQ-023 SHALL, on sys_rst=1 at a clock edge, clear the following to 0:
- data, point, sign, frame_valid, glyph_err
- capture mask, stability counter, digit registers, accumulator
- FSM, which returns to IDLE
REQ-024 SHALL abort any conversion in progress on reset, with no frame_valid pulse.

Configuration
REQ-025 SHALL, when macro SEG_DEC_ERR_CHECK_EN is defined, set glyph_err for a frame containing any code outside REQ-011.
REQ-026 SHALL, without SEG_DEC_ERR_CHECK_EN, tie glyph_err to 0 and decode unknown codes as value 0 with no flag.

Structure
REQ-027 SHALL place glyph constants, NUM_DIGITS=6 and the FSM state encoding in package seg_dec_pkg.
REQ-028 SHALL implement glyph-to-value/flag lookup in sub-module seg_glyph_decode, instantiated once on the live seg bus.

Verification
REQ-029 SHALL verify this scenario: loop back seg_dynamic with data=20'd9876, point=0, sign=0 -> frame_valid pulses; data=9876, point=0, sign=0, glyph_err=0.
REQ-030 SHALL verify this scenario: seg_dynamic with data=20'd123456, point=6'b000100 -> data=123456, point=6'b000100.
REQ-031 SHALL verify this scenario: seg_dynamic with data=20'd42, sign=1 -> data=42, sign=1.
REQ-032 SHALL verify this scenario: with CNT_STABLE=5, sel held 4 cycles then changed -> no mask bit set, no frame_valid.
REQ-033 SHALL verify this scenario: seg=8'hAA on digit 3 with the macro defined -> glyph_err=1 at frame_valid; without the macro, glyph_err=0 and digit 3 counts as 0.
REQ-034 SHALL verify this scenario: sys_rst asserted 3 cycles into CONVERT -> no frame_valid, all outputs 0, the next full frame decodes correctly.

Source files
------------

// File: rtl/seg_dec_pkg.sv
// Shared constants and types for the multiplexed seven-segment decoder:
// active-low glyph codes, digit count, FSM encoding and the per-digit record.
package seg_dec_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_MINUS = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] value;
        logic       dp;
        logic       minus;
        logic       err;
    } digit_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph lookup for one segment pattern (g..a, active low).
// Unknown patterns raise o_err only when SEG_DEC_ERR_CHECK_EN is defined.
module seg_glyph_decode
    import seg_dec_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_value,
    output logic       o_minus,
    output logic       o_err
);

    always_comb begin
        o_value = 4'd0;
        o_minus = 1'b0;
        o_err   = 1'b0;
        case (i_seg)
            GLYPH_0:     o_value = 4'd0;
            GLYPH_1:     o_value = 4'd1;
            GLYPH_2:     o_value = 4'd2;
            GLYPH_3:     o_value = 4'd3;
            GLYPH_4:     o_value = 4'd4;
            GLYPH_5:     o_value = 4'd5;
            GLYPH_6:     o_value = 4'd6;
            GLYPH_7:     o_value = 4'd7;
            GLYPH_8:     o_value = 4'd8;
            GLYPH_9:     o_value = 4'd9;
            GLYPH_MINUS: o_minus = 1'b1;
            GLYPH_BLANK: o_value = 4'd0;
            default: begin
`ifdef SEG_DEC_ERR_CHECK_EN
                o_err = 1'b1;
`else
                o_err = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/seg_dynamic_decoder.sv
// Recovers a 6-digit value from a scanned seven-segment bus: debounces each
// sel/seg pair, latches digits, then converts them to binary (optional glyph
// error flag via SEG_DEC_ERR_CHECK_EN).
module seg_dynamic_decoder
    import seg_dec_pkg::*;
#(
    parameter logic [15:0] CNT_STABLE = 16'd1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  seg,
    input  logic [5:0]  sel,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        frame_valid,
    output logic        glyph_err
);

    localparam logic [15:0] CNT_MAX = CNT_STABLE - 16'd1;

    logic [5:0]                  r_sel_prev;
    logic [7:0]                  r_seg_prev;
    logic [15:0]                 r_cnt;
    logic                        r_captured;
    logic [NUM_DIGITS-1:0]       r_mask;
    digit_t [NUM_DIGITS-1:0]     r_digit;
    digit_t [NUM_DIGITS-1:0]     r_snap;
    logic [19:0]                 r_acc;
    logic [2:0]                  r_step;
    state_t                      r_state;
    logic [19:0]                 r_data;
    logic [5:0]                  r_point;
    logic                        r_sign;
    logic                        r_frame_valid;
    logic                        r_glyph_err;

    state_t                      w_state_next;
    logic                        w_start;
    logic                        w_conv;
    logic                        w_done;
    logic                        w_onehot;
    logic                        w_same;
    logic                        w_capture;
    logic [15:0]                 w_cnt_next;
    logic [3:0]                  w_glyph_value;
    logic                        w_glyph_minus;
    logic                        w_glyph_err;
    digit_t                      w_live;
    logic [2:0]                  w_idx;
    logic [5:0]                  w_point;
    logic                        w_minus_any;
    logic                        w_err_any;

    seg_glyph_decode u_glyph (
        .i_seg   (seg[6:0]),
        .o_value (w_glyph_value),
        .o_minus (w_glyph_minus),
        .o_err   (w_glyph_err)
    );

    assign w_live   = {w_glyph_value, ~seg[7], w_glyph_minus, w_glyph_err};
    assign w_onehot = (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
    assign w_same   = (sel == r_sel_prev) && (seg == r_seg_prev);

    // Counter saturates at CNT_MAX; r_captured blocks a second latch in the same dwell.
    always_comb begin
        w_cnt_next = 16'd0;
        if (w_onehot && w_same) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 16'd1;
        end
    end

    assign w_capture = w_onehot && (w_cnt_next == CNT_MAX) && !(w_same && r_captured);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sel_prev <= 6'd0;
            r_seg_prev <= 8'd0;
            r_cnt      <= 16'd0;
            r_captured <= 1'b0;
            r_mask     <= '0;
            r_digit    <= '0;
        end else begin
            r_sel_prev <= sel;
            r_seg_prev <= seg;
            r_cnt      <= w_cnt_next;
            r_captured <= w_capture || (w_onehot && w_same && r_captured);
            r_mask     <= (w_start ? '0 : r_mask) | (w_capture ? sel : '0);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_capture && sel[i]) begin
                    r_digit[i] <= w_live;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (&r_mask) w_state_next = ST_CONVERT;
            ST_CONVERT: if (r_step == 3'd5) w_state_next = ST_DONE;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start = (r_state == ST_IDLE) && (&r_mask);
        w_conv  = (r_state == ST_CONVERT);
        w_done  = (r_state == ST_DONE);
    end

    assign w_idx = 3'(NUM_DIGITS - 1) - r_step;

    // acc*10 as shift-add, most significant digit first.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_snap <= '0;
            r_acc  <= 20'd0;
            r_step <= 3'd0;
        end else if (w_start) begin
            r_snap <= r_digit;
            r_acc  <= 20'd0;
            r_step <= 3'd0;
        end else if (w_conv) begin
            r_acc  <= (r_acc << 3) + (r_acc << 1) + {16'd0, r_snap[w_idx].value};
            r_step <= r_step + 3'd1;
        end
    end

    always_comb begin
        w_point     = 6'd0;
        w_minus_any = 1'b0;
        w_err_any   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_point[i]  = r_snap[i].dp;
            w_minus_any = w_minus_any | r_snap[i].minus;
            w_err_any   = w_err_any | r_snap[i].err;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_data        <= 20'd0;
            r_point       <= 6'd0;
            r_sign        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_glyph_err   <= 1'b0;
        end else begin
            r_frame_valid <= w_done;
            if (w_done) begin
                r_data      <= r_acc;
                r_point     <= w_point;
                r_sign      <= w_minus_any;
                r_glyph_err <= w_err_any;
            end
        end
    end

    assign data        = r_data;
    assign point       = r_point;
    assign sign        = r_sign;
    assign frame_valid = r_frame_valid;
    assign glyph_err   = r_glyph_err;

endmodule

// File: tb/tb_seg_dynamic_decoder.sv
// Scoreboard bench for seg_dynamic_decoder: a scanner task drives directed
// digit frames, a monitor pops the expected frame on every frame_valid.
`timescale 1ns/1ps
module tb_seg_dynamic_decoder;

    localparam logic [15:0] STABLE = 16'd5;
    localparam int MN = 10;
    localparam int BL = 11;
`ifdef SEG_DEC_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  seg;
    logic [5:0]  sel;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        frame_valid;
    logic        glyph_err;

    seg_dynamic_decoder #(.CNT_STABLE(STABLE)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .seg         (seg),
        .sel         (sel),
        .data        (data),
        .point       (point),
        .sign        (sign),
        .frame_valid (frame_valid),
        .glyph_err   (glyph_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [19:0] data;
        logic [5:0]  point;
        logic        sign;
        logic        err;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_exp;
    int     errors = 0;
    int     checks = 0;
    int     frames_seen = 0;
    int     base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input int d, input logic dp);
        logic [6:0] g;
        case (d)
            0:       g = 7'h40;
            1:       g = 7'h79;
            2:       g = 7'h24;
            3:       g = 7'h30;
            4:       g = 7'h19;
            5:       g = 7'h12;
            6:       g = 7'h02;
            7:       g = 7'h78;
            8:       g = 7'h00;
            9:       g = 7'h10;
            MN:      g = 7'h3F;
            default: g = 7'h7F;
        endcase
        return {~dp, g};
    endfunction

    task automatic expect_frame(input logic [19:0] d, input logic [5:0] p, input logic s, input logic e);
        frame_t f;
        f.data  = d;
        f.point = p;
        f.sign  = s;
        f.err   = e;
        exp_q.push_back(f);
    endtask

    task automatic drive_digit(input int idx, input logic [7:0] code, input int hold);
        #1;
        sel = 6'd1 << idx;
        seg = code;
        repeat (hold) @(posedge sys_clk);
    endtask

    // codes[8*i +: 8] is digit i; scanned from digit 5 down to 0.
    task automatic scan(input logic [47:0] codes, input int hold);
        for (int i = 5; i >= 0; i--) begin
            drive_digit(i, codes[i*8 +: 8], hold);
        end
    endtask

    task automatic idle();
        #1;
        sel = 6'd0;
        seg = 8'hFF;
    endtask

    task automatic quiet(input int cycles);
        idle();
        repeat (cycles) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        idle();
        do begin
            @(posedge sys_clk);
            n++;
            @(negedge sys_clk);
        end while (!frame_valid && n < 20);
        chk({name, " latency"}, n, 8);
    endtask

    initial begin
        forever begin
            @(negedge sys_clk);
            if (frame_valid === 1'b1) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got frame_valid with data=%0d, expected no frame", data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("frame data", data, mon_exp.data);
                    chk("frame point", point, mon_exp.point);
                    chk("frame sign", sign, mon_exp.sign);
                    chk("frame glyph_err", glyph_err, mon_exp.err);
                end
            end
        end
    end

    initial begin
        sys_rst = 1'b1;
        sel     = 6'd0;
        seg     = 8'hFF;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("reset data", data, 0);
        chk("reset point", point, 0);
        chk("reset sign", sign, 0);
        chk("reset frame_valid", frame_valid, 0);
        chk("reset glyph_err", glyph_err, 0);

        expect_frame(20'd9876, 6'd0, 1'b0, 1'b0);
        scan({glyph(BL,0), glyph(BL,0), glyph(9,0), glyph(8,0), glyph(7,0), glyph(6,0)}, 5);
        wait_frame("9876");

        expect_frame(20'd123456, 6'b000100, 1'b0, 1'b0);
        scan({glyph(1,0), glyph(2,0), glyph(3,0), glyph(4,1), glyph(5,0), glyph(6,0)}, 5);
        wait_frame("123456");

        expect_frame(20'd42, 6'd0, 1'b1, 1'b0);
        scan({glyph(BL,0), glyph(BL,0), glyph(BL,0), glyph(MN,0), glyph(4,0), glyph(2,0)}, 5);
        wait_frame("minus42");

        // dwell one cycle short of CNT_STABLE never latches
        base = frames_seen;
        scan({6{glyph(9,0)}}, 4);
        scan({6{glyph(9,0)}}, 4);
        drive_digit(5, glyph(2,0), 5);
        drive_digit(4, glyph(4,0), 5);
        drive_digit(3, glyph(6,0), 5);
        drive_digit(2, glyph(8,0), 5);
        drive_digit(1, glyph(0,0), 5);
        drive_digit(0, glyph(1,0), 4);
        quiet(20);
        chk("short dwell no frame", frames_seen, base);
        expect_frame(20'd246801, 6'd0, 1'b0, 1'b0);
        drive_digit(0, glyph(1,0), 5);
        wait_frame("246801");

        expect_frame(20'd120456, 6'd0, 1'b0, ERR_EN);
        scan({glyph(1,0), glyph(2,0), 8'hAA, glyph(4,0), glyph(5,0), glyph(6,0)}, 5);
        wait_frame("bad glyph");

        // reset lands three cycles into CONVERT
        base = frames_seen;
        scan({glyph(3,0), glyph(1,0), glyph(4,0), glyph(1,0), glyph(5,0), glyph(9,0)}, 5);
        idle();
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("abort data", data, 0);
        chk("abort point", point, 0);
        chk("abort sign", sign, 0);
        chk("abort glyph_err", glyph_err, 0);
        chk("abort frame_valid", frame_valid, 0);
        quiet(15);
        chk("abort no frame", frames_seen, base);

        expect_frame(20'd543210, 6'd0, 1'b0, 1'b0);
        scan({glyph(5,0), glyph(4,0), glyph(3,0), glyph(2,0), glyph(1,0), glyph(0,0)}, 5);
        wait_frame("543210");
        quiet(10);
        chk("hold data", data, 20'd543210);
        chk("hold frame_valid", frame_valid, 0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge sys_clk);
        chk("queue drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
